rom_fuse_lock_requester: RTL and testbench
==========================================

# rom_fuse_lock_requester

Write-side sequencer for the ROM fuse. It accepts a two-step software key sequence on a simple valid/ready write port, drives `REG0` with the fuse magic word for a fixed hold window, and then waits for the fuse's `LOCKED` indication. It reports busy, done, and error status. It sits between the configuration bus and `rom_fuse_main_logic`, and is the only driver of that block's `REG0` input.

## Interface
- `ARM_KEY`, default 32'hA5A5_0001: first key word; arms the sequencer.
- `MAGIC`, default 32'hDEADDEAD: fuse lock word driven on `REG0`.
- `HOLD_CYCLES`, default 2: cycles `REG0` holds `MAGIC`; legal range 1..255.
- `TIMEOUT_CYCLES`, default 16: cycles to wait for `LOCKED`; legal range 1..255.

- `CLK` in 1: sole clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `WR_VALID` in 1: write request.
- `WR_READY` out 1: write accepted when `WR_VALID && WR_READY`.
- `WR_DATA` in 32: write payload.
- `REG0` out 32: word presented to the fuse.
- `LOCKED` in 1: fuse locked indication.
- `BUSY` out 1: high in DRIVE or WAIT.
- `DONE` out 1: sticky; fuse confirmed locked.
- `ERR` out 1: one-cycle pulse on a rejected write or a timeout.
- `ERR_CNT` out 4: saturating count of `ERR` pulses.

## Operation
- States: IDLE, ARMED, DRIVE, WAIT, DONE_ST, FAIL.
- Reset values for every state-dependent output:
  - `REG0`=0, `WR_READY`=0, `BUSY`=0, `DONE`=0, `ERR`=0, `ERR_CNT`=0.
  - State resets to IDLE.
- `WR_READY`:
  - High in IDLE, ARMED and FAIL.
  - Low in DRIVE, WAIT and DONE_ST.
  - Low in the cycle `RST` is high.
- IDLE / FAIL, on an accepted write:
  - Data == `ARM_KEY` → ARMED.
  - Any other data → `ERR` pulse, stay in the current state.
- ARMED, on an accepted write:
  - Data == `MAGIC` → DRIVE; load the hold counter with `HOLD_CYCLES`.
  - Any other data, including `ARM_KEY` → `ERR` pulse, go to IDLE.
- DRIVE:
  - `REG0`=`MAGIC`; the counter decrements each cycle.
  - At count 1 → WAIT, load the timeout counter with `TIMEOUT_CYCLES`.
- WAIT:
  - `REG0`=0.
  - `LOCKED`=1 → DONE_ST.
  - Timeout counter reaches 1 with `LOCKED`=0 → FAIL and `ERR` pulse.
- DONE_ST: terminal until `RST`. `DONE`=1, `REG0`=0, all writes ignored.
- Already-locked fuse: `LOCKED`=1 sampled in any state other than DRIVE → DONE_ST on the next edge. Any write in that same cycle is ignored and produces no `ERR`.
- `LOCKED` rising during DRIVE: ignored. The hold window always completes, then WAIT sees `LOCKED` on its first cycle.
- `ERR_CNT` saturates at 15. Once saturated, further `ERR` pulses still pulse but do not wrap the count.
- `RST` mid-DRIVE: `REG0`=0 on the next edge. The sequence aborts with no `ERR`.

## Timing
- Key write accepted at edge t0 → ARMED at t0+1.
- `MAGIC` write accepted at edge t1:
  - `REG0`=`MAGIC` and `BUSY`=1 from t1+1 through t1+`HOLD_CYCLES`.
  - `REG0`=0 at t1+`HOLD_CYCLES`+1.
- `LOCKED` sampled high at edge tL in WAIT → `DONE`=1 and `BUSY`=0 at tL+1.
- Timeout: with no `LOCKED`, `ERR` pulses at t1+`HOLD_CYCLES`+`TIMEOUT_CYCLES`+1, in the same cycle the state becomes FAIL.
- All outputs are registered. There is no combinational path from `WR_VALID` or `WR_DATA` to any output.

## Configuration
- `ROM_FUSE_REQ_TIMEOUT_EN` defined:
  - The timeout counter and the FAIL state exist as described above.
- Not defined:
  - WAIT waits for `LOCKED` indefinitely.
  - FAIL is unreachable and the timeout counter is not built.
  - `TIMEOUT_CYCLES` is ignored.
  - Rejected writes still drive `ERR` and `ERR_CNT`.

## Structure
- Package `rom_fuse_pkg` holds:
  - the state enum `fuse_req_state_t`;
  - the default `MAGIC` and `ARM_KEY` constants;
  - the counter width constant `FUSE_CNT_W` = 8.
- Sub-module `rom_fuse_down_ctr`: loadable 8-bit down-counter with a `load`/`value`/`en` interface and an `at_one` flag. It is instantiated for the hold counter, and for the timeout counter under `ROM_FUSE_REQ_TIMEOUT_EN`.

## Test plan
- Normal lock:
  - Stimulus: write 32'hA5A5_0001, then 32'hDEADDEAD. The fuse model asserts `LOCKED` 1 cycle after `REG0` returns to 0.
  - Required: `REG0`=32'hDEADDEAD for exactly 2 cycles; `DONE`=1 and stays 1; `ERR_CNT`=0.
- Bad key:
  - Stimulus: write 32'h1234_5678 in IDLE, then 32'hA5A5_0001, then 32'h0.
  - Required: 2 `ERR` pulses, `ERR_CNT`=2, state IDLE, `REG0` never nonzero.
- Timeout (`ROM_FUSE_REQ_TIMEOUT_EN` defined):
  - Stimulus: correct sequence with `LOCKED` tied 0.
  - Required: `ERR` pulse 2+16+1 cycles after the `MAGIC` accept, state FAIL, `WR_READY`=1. A re-armed sequence then succeeds.
- Pre-locked fuse:
  - Stimulus: `LOCKED`=1 from the first cycle after `RST` deasserts.
  - Required: `DONE`=1 on the next cycle; a subsequent write of 32'hA5A5_0001 is ignored (`WR_READY`=0, no `ERR`).
- Reset mid-DRIVE:
  - Stimulus: assert `RST` 1 cycle after the `MAGIC` accept.
  - Required: `REG0`=0, `BUSY`=0, `DONE`=0, `ERR_CNT`=0 after that edge.
- Saturation:
  - Stimulus: 20 bad writes in IDLE.
  - Required: `ERR_CNT`=15, with 20 `ERR` pulses.

Source files
------------

// File: rtl/rom_fuse_pkg.sv
// Shared types and constants for the ROM fuse lock requester.
// Optional timeout/FAIL path: ROM_FUSE_REQ_TIMEOUT_EN.
package rom_fuse_pkg;

    localparam int FUSE_CNT_W = 8;

    localparam logic [31:0] FUSE_MAGIC_DEF   = 32'hDEADDEAD;
    localparam logic [31:0] FUSE_ARM_KEY_DEF = 32'hA5A5_0001;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DRIVE,
        WAIT,
        DONE_ST,
        FAIL
    } fuse_req_state_t;

endpackage

// File: rtl/rom_fuse_down_ctr.sv
// Loadable down-counter with an at-one flag for hold and timeout windows.
// Holds at zero rather than wrapping.
module rom_fuse_down_ctr
    import rom_fuse_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [FUSE_CNT_W-1:0] value,
    input  logic                  en,
    output logic                  at_one
);

    logic [FUSE_CNT_W-1:0] cnt_q;
    logic [FUSE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_one = (cnt_q == FUSE_CNT_W'(1));

endmodule

// File: rtl/rom_fuse_lock_requester.sv
// Key-sequenced REG0 driver that requests and confirms the ROM fuse lock.
// Define ROM_FUSE_REQ_TIMEOUT_EN to build the LOCKED timeout and FAIL state.
module rom_fuse_lock_requester
    import rom_fuse_pkg::*;
#(
    parameter logic [31:0] ARM_KEY        = FUSE_ARM_KEY_DEF,
    parameter logic [31:0] MAGIC          = FUSE_MAGIC_DEF,
    parameter int unsigned HOLD_CYCLES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WR_VALID,
    output logic        WR_READY,
    input  logic [31:0] WR_DATA,
    output logic [31:0] REG0,
    input  logic        LOCKED,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [3:0]  ERR_CNT
);

    fuse_req_state_t state_q, state_d;

    logic [31:0] reg0_q;
    logic        rdy_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q, err_d;
    logic [3:0]  err_cnt_q;

    logic accept;
    logic hold_load;
    logic hold_at_one;
    logic tmo_at_one;

    assign accept = WR_VALID && rdy_q;

    rom_fuse_down_ctr u_hold_ctr (
        .clk    (CLK),
        .rst    (RST),
        .load   (hold_load),
        .value  (FUSE_CNT_W'(HOLD_CYCLES)),
        .en     (state_q == DRIVE),
        .at_one (hold_at_one)
    );

`ifdef ROM_FUSE_REQ_TIMEOUT_EN
    rom_fuse_down_ctr u_tmo_ctr (
        .clk    (CLK),
        .rst    (RST),
        .load   ((state_q == DRIVE) && hold_at_one),
        .value  (FUSE_CNT_W'(TIMEOUT_CYCLES)),
        .en     (state_q == WAIT),
        .at_one (tmo_at_one)
    );
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_at_one = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        hold_load = 1'b0;
        // A fuse that already reports LOCKED wins over any pending write.
        if (LOCKED && (state_q != DRIVE)) begin
            state_d = DONE_ST;
        end else begin
            unique case (state_q)
                IDLE, FAIL: begin
                    if (accept) begin
                        if (WR_DATA == ARM_KEY) state_d = ARMED;
                        else                    err_d   = 1'b1;
                    end
                end
                ARMED: begin
                    if (accept) begin
                        if (WR_DATA == MAGIC) begin
                            state_d   = DRIVE;
                            hold_load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    if (hold_at_one) state_d = WAIT;
                end
                WAIT: begin
                    if (tmo_at_one) begin
                        state_d = FAIL;
                        err_d   = 1'b1;
                    end
                end
                DONE_ST: begin
                    state_d = DONE_ST;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            reg0_q    <= '0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            reg0_q  <= (state_d == DRIVE) ? MAGIC : '0;
            rdy_q   <= (state_d == IDLE) || (state_d == ARMED)
                    || (state_d == FAIL);
            busy_q  <= (state_d == DRIVE) || (state_d == WAIT);
            done_q  <= (state_d == DONE_ST);
            err_q   <= err_d;
            if (err_d && (err_cnt_q != 4'hF)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign WR_READY = rdy_q;
    assign REG0     = reg0_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign ERR_CNT  = err_cnt_q;

endmodule

// File: tb/tb_rom_fuse_lock_requester.sv
// Directed self-checking bench for rom_fuse_lock_requester.
// Timeout scenario is selected by ROM_FUSE_REQ_TIMEOUT_EN.
module tb_rom_fuse_lock_requester;

    localparam logic [31:0] KEY = 32'hA5A5_0001;
    localparam logic [31:0] MAG = 32'hDEADDEAD;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        WR_VALID = 1'b0;
    logic        WR_READY;
    logic [31:0] WR_DATA = '0;
    logic [31:0] REG0;
    logic        LOCKED = 1'b0;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [3:0]  ERR_CNT;

    int checks = 0;
    int failures = 0;
    int err_pulses = 0;
    bit reg0_seen = 1'b0;

    rom_fuse_lock_requester dut (
        .CLK      (CLK),
        .RST      (RST),
        .WR_VALID (WR_VALID),
        .WR_READY (WR_READY),
        .WR_DATA  (WR_DATA),
        .REG0     (REG0),
        .LOCKED   (LOCKED),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR),
        .ERR_CNT  (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (ERR === 1'b1) err_pulses++;
        if (REG0 !== 32'h0) reg0_seen = 1'b1;
    end

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        LOCKED = 1'b0;
        WR_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        err_pulses = 0;
        reg0_seen = 1'b0;
    endtask

    task automatic wr(input logic [31:0] d);
        int n;
        n = 0;
        @(negedge CLK);
        WR_VALID = 1'b1;
        WR_DATA = d;
        while (WR_READY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL wr_ready_wait data=%h ready=%b need 1", d, WR_READY);
        end
        @(posedge CLK);
        #1;
        WR_VALID = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (WR_READY !== 1'b0 || REG0 !== 32'h0 || BUSY !== 1'b0
            || DONE !== 1'b0 || ERR !== 1'b0 || ERR_CNT !== 4'h0) begin
            failures++;
            $display("FAIL reset_vals rdy=%b reg0=%h busy=%b done=%b err=%b cnt=%0d need 0",
                     WR_READY, REG0, BUSY, DONE, ERR, ERR_CNT);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (WR_READY !== 1'b1) begin
            failures++;
            $display("FAIL idle_ready got=%b need 1", WR_READY);
        end
    endtask

    task automatic test_normal_lock();
        int magic_cycles;
        magic_cycles = 0;
        do_reset();
        wr(KEY);
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || WR_READY !== 1'b1 || REG0 !== 32'h0) begin
            failures++;
            $display("FAIL armed busy=%b rdy=%b reg0=%h need 0 1 0", BUSY, WR_READY, REG0);
        end
        wr(MAG);
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            if (REG0 === MAG) magic_cycles++;
            if (c <= 2) begin
                checks++;
                if (REG0 !== MAG || BUSY !== 1'b1 || WR_READY !== 1'b0) begin
                    failures++;
                    $display("FAIL drive c=%0d reg0=%h busy=%b rdy=%b need %h 1 0",
                             c, REG0, BUSY, WR_READY, MAG);
                end
            end
            if (c == 3) begin
                checks++;
                if (REG0 !== 32'h0 || BUSY !== 1'b1) begin
                    failures++;
                    $display("FAIL wait_entry reg0=%h busy=%b need 0 1", REG0, BUSY);
                end
            end
            if (c == 4) LOCKED = 1'b1;
            if (c == 5) begin
                checks++;
                if (DONE !== 1'b1 || BUSY !== 1'b0) begin
                    failures++;
                    $display("FAIL lock_done done=%b busy=%b need 1 0", DONE, BUSY);
                end
            end
        end
        LOCKED = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (magic_cycles != 2) begin
            failures++;
            $display("FAIL magic_len got=%0d need 2", magic_cycles);
        end
        checks++;
        if (DONE !== 1'b1 || ERR_CNT !== 4'h0 || WR_READY !== 1'b0 || err_pulses != 0) begin
            failures++;
            $display("FAIL done_sticky done=%b cnt=%0d rdy=%b pulses=%0d need 1 0 0 0",
                     DONE, ERR_CNT, WR_READY, err_pulses);
        end
    endtask

    task automatic test_bad_key();
        do_reset();
        wr(32'h1234_5678);
        @(negedge CLK);
        checks++;
        if (ERR !== 1'b1 || WR_READY !== 1'b1) begin
            failures++;
            $display("FAIL bad_key_err err=%b rdy=%b need 1 1", ERR, WR_READY);
        end
        @(negedge CLK);
        checks++;
        if (ERR !== 1'b0) begin
            failures++;
            $display("FAIL err_one_cycle err=%b need 0", ERR);
        end
        wr(KEY);
        wr(32'h0);
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1;
        checks++;
        if (err_pulses != 2 || ERR_CNT !== 4'd2 || BUSY !== 1'b0 || reg0_seen) begin
            failures++;
            $display("FAIL bad_seq pulses=%0d cnt=%0d busy=%b reg0_seen=%b need 2 2 0 0",
                     err_pulses, ERR_CNT, BUSY, reg0_seen);
        end
        wr(MAG);
        repeat (3) @(negedge CLK);
        checks++;
        if (ERR_CNT !== 4'd3 || reg0_seen || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL back_in_idle cnt=%0d reg0_seen=%b busy=%b need 3 0 0",
                     ERR_CNT, reg0_seen, BUSY);
        end
    endtask

`ifdef ROM_FUSE_REQ_TIMEOUT_EN
    task automatic test_timeout();
        int err_at;
        err_at = -1;
        do_reset();
        wr(KEY);
        wr(MAG);
        for (int c = 1; c <= 25; c++) begin
            @(negedge CLK);
            if (ERR === 1'b1 && err_at < 0) err_at = c;
            if (c == 19) begin
                checks++;
                if (ERR !== 1'b1 || WR_READY !== 1'b1 || BUSY !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_fail err=%b rdy=%b busy=%b need 1 1 0",
                             ERR, WR_READY, BUSY);
                end
            end
            if (c == 18) begin
                checks++;
                if (BUSY !== 1'b1 || ERR !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_wait busy=%b err=%b need 1 0", BUSY, ERR);
                end
            end
        end
        checks++;
        if (err_at != 19 || ERR_CNT !== 4'd1) begin
            failures++;
            $display("FAIL timeout_cycle got=%0d cnt=%0d need 19 1", err_at, ERR_CNT);
        end
        wr(KEY);
        wr(MAG);
        repeat (3) @(negedge CLK);
        LOCKED = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (DONE !== 1'b1 || ERR_CNT !== 4'd1) begin
            failures++;
            $display("FAIL rearm_done done=%b cnt=%0d need 1 1", DONE, ERR_CNT);
        end
        LOCKED = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        int bad;
        bad = 0;
        do_reset();
        wr(KEY);
        wr(MAG);
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            if (BUSY !== 1'b1 || ERR !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL wait_forever bad_cycles=%0d need 0", bad);
        end
        LOCKED = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || ERR_CNT !== 4'd0) begin
            failures++;
            $display("FAIL late_lock done=%b busy=%b cnt=%0d need 1 0 0", DONE, BUSY, ERR_CNT);
        end
        LOCKED = 1'b0;
    endtask
`endif

    task automatic test_prelocked();
        @(negedge CLK);
        RST = 1'b1;
        LOCKED = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        LOCKED = 1'b1;
        err_pulses = 0;
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b1 || WR_READY !== 1'b0) begin
            failures++;
            $display("FAIL prelock_done done=%b rdy=%b need 1 0", DONE, WR_READY);
        end
        WR_VALID = 1'b1;
        WR_DATA = KEY;
        repeat (3) @(negedge CLK);
        WR_VALID = 1'b0;
        LOCKED = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (DONE !== 1'b1 || WR_READY !== 1'b0 || ERR_CNT !== 4'd0
            || err_pulses != 0 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL prelock_ignore done=%b rdy=%b cnt=%0d pulses=%0d busy=%b need 1 0 0 0 0",
                     DONE, WR_READY, ERR_CNT, err_pulses, BUSY);
        end
    endtask

    task automatic test_reset_mid_drive();
        do_reset();
        wr(KEY);
        wr(MAG);
        @(negedge CLK);
        checks++;
        if (REG0 !== MAG || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL pre_abort reg0=%h busy=%b need %h 1", REG0, BUSY, MAG);
        end
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (REG0 !== 32'h0 || BUSY !== 1'b0 || DONE !== 1'b0
            || ERR_CNT !== 4'd0 || ERR !== 1'b0) begin
            failures++;
            $display("FAIL abort reg0=%h busy=%b done=%b cnt=%0d err=%b need 0",
                     REG0, BUSY, DONE, ERR_CNT, ERR);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            wr(32'h0BAD_0000 + i);
            if (i == 14) begin
                #1;
                checks++;
                if (ERR_CNT !== 4'd15) begin
                    failures++;
                    $display("FAIL sat_reach got=%0d need 15", ERR_CNT);
                end
            end
        end
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1;
        checks++;
        if (ERR_CNT !== 4'd15 || err_pulses != 20) begin
            failures++;
            $display("FAIL saturate cnt=%0d pulses=%0d need 15 20", ERR_CNT, err_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_normal_lock();
        test_bad_key();
`ifdef ROM_FUSE_REQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_prelocked();
        test_reset_mid_drive();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
